bcd_countdown_timer: RTL

//  Downstream consumer of the minute-adjust stage. Holds a 16-bit BCD MM:SS value
//  {min_tens, min_units, sec_tens, sec_units}, loaded from the adjust stage's 16-bit

---
 rtl/timer_pkg.sv | 38 +++
 rtl/bcd_digit_down.sv | 24 ++
 rtl/bcd_countdown_timer.sv | 109 ++++++++++
 3 files changed

// File: rtl/timer_pkg.sv
// Shared types and constants for the BCD MM:SS countdown timer.
// Holds the FSM state enum, digit limits, field positions and the load sanitiser.
package timer_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        PAUSED  = 2'd2,
        EXPIRED = 2'd3
    } state_t;

    localparam logic [3:0] DIGIT_MAX    = 4'd9;
    localparam logic [3:0] SEC_TENS_MAX = 4'd5;

    localparam int SEC_UNITS_LSB = 0;
    localparam int SEC_TENS_LSB  = 4;
    localparam int MIN_UNITS_LSB = 8;
    localparam int MIN_TENS_LSB  = 12;

    function automatic logic [3:0] digit_limit(input int idx);
        return (idx * 4 == SEC_TENS_LSB) ? SEC_TENS_MAX : DIGIT_MAX;
    endfunction

    // Out-of-range digits clamp to their limit rather than being rejected.
    function automatic logic [15:0] sanitise_bcd(input logic [15:0] raw);
        logic [15:0] res;
        logic [3:0]  dig;
        logic [3:0]  lim;
        res = '0;
        for (int i = 0; i < 4; i++) begin
            dig = raw[i*4 +: 4];
            lim = digit_limit(i);
            res[i*4 +: 4] = (dig > lim) ? lim : dig;
        end
        return res;
    endfunction

endpackage

// File: rtl/bcd_digit_down.sv
// One BCD digit of a decrementing borrow chain: wraps 0 -> max when borrowing.
// Combinational, zero latency; no flow control.
module bcd_digit_down (
    input  logic [3:0] digit,
    input  logic [3:0] max,
    input  logic       borrow_in,
    output logic [3:0] digit_next,
    output logic       borrow_out
);

    always_comb begin
        digit_next = digit;
        borrow_out = 1'b0;
        if (borrow_in) begin
            if (digit == 4'd0) begin
                digit_next = max;
                borrow_out = 1'b1;
            end else begin
                digit_next = digit - 4'd1;
            end
        end
    end

endmodule

// File: rtl/bcd_countdown_timer.sv
// MM:SS BCD countdown with load sanitising, pause/resume and a one-shot expiry pulse.
// time_out updates the cycle after tick; done/running are registered with time_out.
// Strobe-driven, no backpressure: commands are prioritised clear > load > pause > start.
module bcd_countdown_timer
    import timer_pkg::*;
#(
    parameter int CLK_HZ = 50_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [15:0] time_in,
    input  logic        start,
    input  logic        pause,
    input  logic        clear,
    output logic [15:0] time_out,
    output logic        running,
    output logic        tick,
    output logic        done
);

    localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_HZ - 1);

    state_t          state_q, state_d;
    logic [PW-1:0]   presc_q, presc_d;
    logic [15:0]     time_q, time_d;
    logic            running_q, running_d;
    logic            done_q, done_d;

    logic [15:0]     time_dec;
    logic [4:0]      borrow;
    logic            tick_w;

    assign borrow[0] = 1'b1;

    for (genvar g = 0; g < 4; g++) begin : g_digit
        bcd_digit_down u_digit (
            .digit      (time_q[g*4 +: 4]),
            .max        (digit_limit(g)),
            .borrow_in  (borrow[g]),
            .digit_next (time_dec[g*4 +: 4]),
            .borrow_out (borrow[g+1])
        );
    end

    // A wrap coinciding with pause or clear is dropped entirely.
    assign tick_w = (state_q == RUN) && (presc_q == PRESC_LAST) && !clear && !pause;

    always_comb begin
        state_d = state_q;
        presc_d = presc_q;
        time_d  = time_q;
        done_d  = 1'b0;
        if (clear) begin
            state_d = IDLE;
            presc_d = '0;
            time_d  = '0;
        end else if (load && state_q != RUN) begin
            state_d = IDLE;
            presc_d = '0;
            time_d  = sanitise_bcd(time_in);
        end else if (state_q == RUN && pause) begin
            state_d = PAUSED;
        end else if (start && state_q != RUN && time_q != 16'h0000) begin
            state_d = RUN;
            if (state_q != PAUSED) begin
                presc_d = '0;
            end
        end else if (state_q == RUN) begin
            if (tick_w) begin
                presc_d = '0;
                // borrow[4] means the chain underflowed; hold at zero instead.
                if (!borrow[4]) begin
                    time_d = time_dec;
                end
                if (borrow[4] || time_dec == 16'h0000) begin
                    state_d = EXPIRED;
                    done_d  = !borrow[4];
                end
            end else begin
                presc_d = presc_q + 1'b1;
            end
        end
        running_d = (state_d == RUN);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            presc_q   <= '0;
            time_q    <= '0;
            running_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            presc_q   <= presc_d;
            time_q    <= time_d;
            running_q <= running_d;
            done_q    <= done_d;
        end
    end

    assign time_out = time_q;
    assign running  = running_q;
    assign tick     = tick_w;
    assign done     = done_q;

endmodule
